// File: rtl/btb_pkg.sv
// Shared types and helpers for the set-associative branch target buffer.
// Holds the entry record, counter constants and the saturating counter update.
package btb_pkg;

  localparam logic [1:0] CTR_MAX   = 2'd3;
  localparam logic [1:0] CTR_ALLOC = 2'd2;
  localparam int         TAG_MAX_W = 30;

  // Tag field sized for the smallest legal set count; narrower tags are zero-extended.
  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    logic                 jump;
    logic                 branch;
    logic [1:0]           ctr;
  } btb_entry_t;

  function automatic logic [1:0] sat_ctr_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'd1;
    else       return (ctr == 2'd0)    ? 2'd0    : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/btb_victim_sel.sv
// Per-set round-robin replacement pointers plus an invalid-first priority encoder.
// Produces the way to allocate into for the set currently being updated.
module btb_victim_sel #(
  parameter int NUM_SETS = 4,
  parameter int NUM_WAYS = 2,
  parameter int IDX_W    = $clog2(NUM_SETS),
  parameter int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                reset_ni,
  input  logic                flush_i,
  input  logic [IDX_W-1:0]    set_i,
  input  logic [NUM_WAYS-1:0] valid_i,
  input  logic                advance_i,
  output logic [WAY_W-1:0]    victim_o,
  output logic                full_o
);

  logic [WAY_W-1:0] rr_ptr [NUM_SETS];

  // The pointer only moves when a full set is overwritten; power-of-2 ways wrap naturally.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int s = 0; s < NUM_SETS; s++) rr_ptr[s] <= '0;
    end else if (flush_i) begin
      for (int s = 0; s < NUM_SETS; s++) rr_ptr[s] <= '0;
    end else if (advance_i) begin
      rr_ptr[set_i] <= rr_ptr[set_i] + WAY_W'(1);
    end
  end

  always_comb begin
    full_o   = &valid_i;
    victim_o = rr_ptr[set_i];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) victim_o = WAY_W'(w);
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// N-way set-associative BTB: combinational fetch lookup, registered execute updates.
// Optional statistics counters are built when BTB_STATS_EN is defined.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int NUM_SETS = 4,
  parameter int NUM_WAYS = 2,
  parameter int IDX_W    = $clog2(NUM_SETS),
  parameter int WAY_W    = $clog2(NUM_WAYS),
  parameter int TAG_W    = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        reset_ni,
  input  logic [31:0] lookup_pc_i,
  output logic        hit_o,
  output logic [31:0] target_o,
  output logic        jump_o,
  output logic        branch_o,
  output logic        pred_taken_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_jump_i,
  input  logic        upd_branch_i,
  input  logic        upd_taken_i,
  input  logic        flush_i
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] stat_lookup_hits_o,
  output logic [31:0] stat_allocs_o,
  output logic [31:0] stat_evicts_o
`endif
);

  logic             valid_q  [NUM_SETS][NUM_WAYS];
  logic [1:0]       ctr_q    [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0] tag_q    [NUM_SETS][NUM_WAYS];
  logic [31:0]      target_q [NUM_SETS][NUM_WAYS];
  logic             jump_q   [NUM_SETS][NUM_WAYS];
  logic             branch_q [NUM_SETS][NUM_WAYS];

  logic [IDX_W-1:0] lk_set, up_set;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;
  logic [WAY_W-1:0] lk_way, up_way, victim;
  logic             victim_full;
  logic [NUM_WAYS-1:0] up_valid_vec;
  btb_entry_t       lk_ent;
  logic             up_is_jump, up_is_br, up_active, hit_wr, alloc;
  logic             unused_ok;

  assign lk_set = lookup_pc_i[IDX_W+1:2];
  assign lk_tag = lookup_pc_i[31:IDX_W+2];
  assign up_set = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[31:IDX_W+2];

  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    up_hit = 1'b0;
    up_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      up_valid_vec[w] = valid_q[up_set][w];
      if (valid_q[lk_set][w] && tag_q[lk_set][w] == lk_tag) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
      if (valid_q[up_set][w] && tag_q[up_set][w] == up_tag) begin
        up_hit = 1'b1;
        up_way = WAY_W'(w);
      end
    end
  end

  // Miss view is forced to all-zero so stale data never leaks to fetch.
  always_comb begin
    lk_ent = '0;
    if (lk_hit) begin
      lk_ent.valid  = 1'b1;
      lk_ent.tag    = TAG_MAX_W'(tag_q[lk_set][lk_way]);
      lk_ent.target = target_q[lk_set][lk_way];
      lk_ent.jump   = jump_q[lk_set][lk_way];
      lk_ent.branch = branch_q[lk_set][lk_way];
      lk_ent.ctr    = ctr_q[lk_set][lk_way];
    end
  end

  assign hit_o        = lk_ent.valid;
  assign target_o     = lk_ent.target;
  assign jump_o       = lk_ent.jump;
  assign branch_o     = lk_ent.branch;
  assign pred_taken_o = lk_ent.valid & (lk_ent.jump | lk_ent.ctr[1]);

  // An instruction flagged as both jump and branch is stored as a plain jump.
  assign up_is_jump = upd_jump_i;
  assign up_is_br   = upd_branch_i & ~upd_jump_i;
  assign up_active  = upd_valid_i & ~flush_i & (up_is_jump | up_is_br);
  assign hit_wr     = up_active & up_hit;
  assign alloc      = up_active & ~up_hit & (up_is_jump | upd_taken_i);

  btb_victim_sel #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS),
    .IDX_W    (IDX_W),
    .WAY_W    (WAY_W)
  ) u_victim_sel (
    .clk       (clk),
    .reset_ni  (reset_ni),
    .flush_i   (flush_i),
    .set_i     (up_set),
    .valid_i   (up_valid_vec),
    .advance_i (alloc & victim_full),
    .victim_o  (victim),
    .full_o    (victim_full)
  );

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          ctr_q[s][w]   <= 2'd0;
        end
    end else if (flush_i) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++) valid_q[s][w] <= 1'b0;
    end else if (hit_wr) begin
      if (up_is_br) begin
        if (!upd_taken_i && ctr_q[up_set][up_way] == 2'd0) valid_q[up_set][up_way] <= 1'b0;
        else ctr_q[up_set][up_way] <= sat_ctr_update(ctr_q[up_set][up_way], upd_taken_i);
      end
    end else if (alloc) begin
      valid_q[up_set][victim] <= 1'b1;
      ctr_q[up_set][victim]   <= CTR_ALLOC;
    end
  end

  // Payload fields carry no reset; the valid bit gates every use of them.
  always_ff @(posedge clk) begin
    if (hit_wr && (up_is_jump || upd_taken_i)) begin
      target_q[up_set][up_way] <= upd_target_i;
    end else if (alloc) begin
      tag_q[up_set][victim]    <= up_tag;
      target_q[up_set][victim] <= upd_target_i;
      jump_q[up_set][victim]   <= up_is_jump;
      branch_q[up_set][victim] <= up_is_br;
    end
  end

`ifdef BTB_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni || flush_i) begin
      stat_lookup_hits_o <= '0;
      stat_allocs_o      <= '0;
      stat_evicts_o      <= '0;
    end else begin
      if (hit_o)               stat_lookup_hits_o <= sat_inc32(stat_lookup_hits_o);
      if (alloc)               stat_allocs_o      <= sat_inc32(stat_allocs_o);
      if (alloc && victim_full) stat_evicts_o     <= sat_inc32(stat_evicts_o);
    end
  end
`endif

  assign unused_ok = ^{lookup_pc_i[1:0], upd_pc_i[1:0], lk_ent.tag};

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc: directed scenarios plus randomized traffic
// compared every cycle against a behavioural BTB model (BTB_STATS_EN aware).
module tb_btb_assoc;

  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        hit, jump, branch, pred_taken;
  logic [31:0] target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0, upd_target = '0;
  logic        upd_jump = 1'b0, upd_branch = 1'b0, upd_taken = 1'b0;
  logic        flush = 1'b0;
`ifdef BTB_STATS_EN
  logic [31:0] st_hits, st_allocs, st_evicts;
`endif

  int tests = 0;
  int fails = 0;

  btb_assoc dut (
    .clk          (clk),
    .reset_ni     (reset_ni),
    .lookup_pc_i  (lookup_pc),
    .hit_o        (hit),
    .target_o     (target),
    .jump_o       (jump),
    .branch_o     (branch),
    .pred_taken_o (pred_taken),
    .upd_valid_i  (upd_valid),
    .upd_pc_i     (upd_pc),
    .upd_target_i (upd_target),
    .upd_jump_i   (upd_jump),
    .upd_branch_i (upd_branch),
    .upd_taken_i  (upd_taken),
`ifdef BTB_STATS_EN
    .stat_lookup_hits_o (st_hits),
    .stat_allocs_o      (st_allocs),
    .stat_evicts_o      (st_evicts),
`endif
    .flush_i      (flush)
  );

  always #5 clk = ~clk;

  // Behavioural model: 4 sets x 2 ways, entries identified by the full word address.
  bit          m_v   [4][2];
  logic [29:0] m_pcw [4][2];
  logic [31:0] m_tgt [4][2];
  bit          m_j   [4][2];
  bit          m_b   [4][2];
  int          m_c   [4][2];
  int          m_rr  [4];
  int          m_hits, m_allocs, m_evicts;

  function automatic int mfind(input logic [31:0] pc);
    int s;
    s = int'(pc[3:2]);
    for (int w = 0; w < 2; w++)
      if (m_v[s][w] && m_pcw[s][w] == pc[31:2]) return w;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
    end
  endtask

  always @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int s = 0; s < 4; s++) begin
        m_rr[s] = 0;
        for (int w = 0; w < 2; w++) begin m_v[s][w] = 0; m_c[s][w] = 0; end
      end
      m_hits = 0; m_allocs = 0; m_evicts = 0;
    end else begin
      int s, w, v;
      if (mfind(lookup_pc) >= 0) m_hits++;
      if (flush) begin
        for (int i = 0; i < 4; i++) begin
          m_rr[i] = 0;
          for (int k = 0; k < 2; k++) m_v[i][k] = 0;
        end
        m_hits = 0; m_allocs = 0; m_evicts = 0;
      end else if (upd_valid && (upd_jump || upd_branch)) begin
        s = int'(upd_pc[3:2]);
        w = mfind(upd_pc);
        if (w >= 0) begin
          if (upd_jump) m_tgt[s][w] = upd_target;
          else if (upd_taken) begin
            m_tgt[s][w] = upd_target;
            if (m_c[s][w] < 3) m_c[s][w]++;
          end else if (m_c[s][w] == 0) m_v[s][w] = 0;
          else m_c[s][w]--;
        end else if (upd_jump || upd_taken) begin
          v = -1;
          for (int k = 1; k >= 0; k--) if (!m_v[s][k]) v = k;
          if (v < 0) begin
            v = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % 2;
            m_evicts++;
          end
          m_allocs++;
          m_v[s][v] = 1; m_pcw[s][v] = upd_pc[31:2]; m_tgt[s][v] = upd_target;
          m_j[s][v] = upd_jump; m_b[s][v] = upd_branch && !upd_jump; m_c[s][v] = 2;
        end
      end
    end
  end

  // Single compare process: outputs are checked against the model every cycle.
  always @(negedge clk) begin
    int w, s;
    bit eh;
    w = mfind(lookup_pc);
    s = int'(lookup_pc[3:2]);
    eh = (w >= 0);
    chk("hit_o", {31'd0, hit}, {31'd0, eh});
    chk("target_o", target, eh ? m_tgt[s][w] : 32'd0);
    chk("jump_o", {31'd0, jump}, {31'd0, eh && m_j[s][w]});
    chk("branch_o", {31'd0, branch}, {31'd0, eh && m_b[s][w]});
    chk("pred_taken_o", {31'd0, pred_taken}, {31'd0, eh && (m_j[s][w] || m_c[s][w] >= 2)});
`ifdef BTB_STATS_EN
    chk("stat_lookup_hits_o", st_hits, m_hits);
    chk("stat_allocs_o", st_allocs, m_allocs);
    chk("stat_evicts_o", st_evicts, m_evicts);
`endif
  end

  task automatic drive(input logic [31:0] lk, input logic uv, input logic [31:0] pc,
                       input logic [31:0] tg, input logic j, input logic b, input logic t,
                       input logic fl);
    @(posedge clk); #2;
    lookup_pc = lk; upd_valid = uv; upd_pc = pc; upd_target = tg;
    upd_jump = j; upd_branch = b; upd_taken = t; flush = fl;
  endtask

  task automatic look(input logic [31:0] lk);
    drive(lk, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset_ni = 1'b0; upd_valid = 1'b0; flush = 1'b0;
    @(posedge clk); #2;
    reset_ni = 1'b1;
  endtask

  function automatic logic [31:0] rpc();
    return 32'h4000 | (32'($urandom_range(0, 5)) << 4) | (32'($urandom_range(0, 3)) << 2);
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #2 reset_ni = 1'b1;

    look(32'h100);
    chk("reset_hit", {31'd0, hit}, 32'd0);
    chk("reset_target", target, 32'd0);
    chk("reset_pred", {31'd0, pred_taken}, 32'd0);

    drive(32'h100, 1'b1, 32'h100, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("same_cycle_no_bypass", {31'd0, hit}, 32'd0);
    look(32'h100);
    chk("jump_hit", {31'd0, hit}, 32'd1);
    chk("jump_flag", {31'd0, jump}, 32'd1);
    chk("jump_target", target, 32'h400);
    chk("jump_pred", {31'd0, pred_taken}, 32'd1);

    do_reset();
    drive(32'h0, 1'b1, 32'h100, 32'h1000, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(32'h0, 1'b1, 32'h110, 32'h1100, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(32'h0, 1'b1, 32'h120, 32'h1200, 1'b0, 1'b1, 1'b1, 1'b0);
    look(32'h100);
    chk("evicted_0x100", {31'd0, hit}, 32'd0);
    look(32'h110);
    chk("kept_0x110", target, 32'h1100);
    look(32'h120);
    chk("new_0x120", target, 32'h1200);

    do_reset();
    drive(32'h0, 1'b1, 32'h200, 32'h2000, 1'b0, 1'b1, 1'b1, 1'b0);
    look(32'h200);
    chk("alloc_pred", {31'd0, pred_taken}, 32'd1);
    drive(32'h0, 1'b1, 32'h200, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    look(32'h200);
    chk("nt1_hit", {31'd0, hit}, 32'd1);
    chk("nt1_pred", {31'd0, pred_taken}, 32'd0);
    drive(32'h0, 1'b1, 32'h200, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    look(32'h200);
    chk("nt2_hit", {31'd0, hit}, 32'd1);
    drive(32'h0, 1'b1, 32'h200, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    look(32'h200);
    chk("nt3_invalid", {31'd0, hit}, 32'd0);

    drive(32'h0, 1'b1, 32'h300, 32'h3000, 1'b0, 1'b1, 1'b0, 1'b0);
    look(32'h300);
    chk("nt_miss_no_alloc", {31'd0, hit}, 32'd0);

    drive(32'h0, 1'b1, 32'h104, 32'h1400, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(32'h0, 1'b1, 32'h108, 32'h1800, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(32'h0, 1'b1, 32'h10C, 32'h1C00, 1'b1, 1'b0, 1'b0, 1'b0);
    look(32'h108);
    chk("filled_0x108", target, 32'h1800);
    drive(32'h108, 1'b1, 32'h500, 32'h5000, 1'b1, 1'b0, 1'b0, 1'b1);
    look(32'h104);
    chk("flush_0x104", {31'd0, hit}, 32'd0);
`ifdef BTB_STATS_EN
    chk("flush_stat_hits", st_hits, 32'd0);
    chk("flush_stat_allocs", st_allocs, 32'd0);
    chk("flush_stat_evicts", st_evicts, 32'd0);
`endif
    look(32'h108);
    chk("flush_0x108", {31'd0, hit}, 32'd0);
    look(32'h10C);
    chk("flush_0x10C", {31'd0, hit}, 32'd0);
    look(32'h500);
    chk("flush_drops_update", {31'd0, hit}, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      int r;
      logic j, b;
      r = int'($urandom_range(0, 9));
      j = (r < 4);
      b = (r >= 4 && r < 9);
      drive(rpc(), ($urandom_range(0, 9) < 6), rpc(), $urandom, j, b,
            1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
      if (i == 1500) reset_ni = 1'b0;
      if (i == 1502) reset_ni = 1'b1;
    end
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
